// File: rtl/tvip_axi_sample_delay_fifo.sv
// Valid/ready delay element: holds each accepted beat for a programmable minimum latency,
// with optional LFSR-driven valid stalls and drain-then-bypass mode switching.
module tvip_axi_sample_delay_fifo #(
    parameter int          DATA_WIDTH = 32,
    parameter int          DEPTH      = 8,
    parameter int          MAX_DELAY  = 15,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_enable,
    input  logic [$clog2(MAX_DELAY+1)-1:0]    i_delay,
    input  logic [3:0]                        i_stall_threshold,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [DATA_WIDTH-1:0]             i_d,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [DATA_WIDTH-1:0]             o_d,
    output logic [$clog2(DEPTH+1)-1:0]        o_count
);

    localparam int DLY_W = $clog2(MAX_DELAY + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [DLY_W-1:0] DELAY_CAP = DLY_W'(MAX_DELAY);

    typedef enum logic [1:0] {
        ST_BYPASS = 2'd0,
        ST_DELAY  = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [PTR_W-1:0]       wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]       rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]       count_reg, count_next;
    logic [15:0]            lfsr_reg, lfsr_next;
    logic                   presented_reg, presented_next;

    logic [DATA_WIDTH-1:0]  data_mem [DEPTH];
    logic [DLY_W-1:0]       cd_vec   [DEPTH];

    logic                   queue_mode;
    logic                   full;
    logic                   head_eligible;
    logic                   stall_hit;
    logic                   q_valid;
    logic                   push;
    logic                   pop;
    logic [DLY_W-1:0]       delay_load;

    // Pointer wrap that also works for non-power-of-two depths
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR)
            return '0;
        else
            return p + PTR_W'(1);
    endfunction

    assign queue_mode    = (state_reg != ST_BYPASS);
    assign full          = (count_reg == FULL_CNT);
    assign delay_load    = (i_delay > DELAY_CAP) ? DELAY_CAP : i_delay;
    assign head_eligible = (count_reg != '0) && (cd_vec[rd_ptr_reg] == '0);
    assign stall_hit     = (lfsr_reg[3:0] < i_stall_threshold);
    // A beat already presented is never withdrawn, whatever the LFSR says now
    assign q_valid       = queue_mode && head_eligible && (presented_reg || !stall_hit);

    assign push = (state_reg == ST_DELAY) && i_valid && !full;
    assign pop  = q_valid && i_ready;

    always_comb begin
        o_valid = 1'b0;
        o_ready = 1'b0;
        o_d     = i_d;
        if (!i_rst) begin
            if (queue_mode) begin
                o_valid = q_valid;
                o_ready = (state_reg == ST_DELAY) && !full;
                o_d     = data_mem[rd_ptr_reg];
            end else begin
                o_valid = i_valid;
                o_ready = i_ready;
                o_d     = i_d;
            end
        end
    end

    assign o_count = count_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
        wr_ptr_next = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    end

    always_comb begin
        presented_next = presented_reg;
        if (!queue_mode)
            presented_next = 1'b0;
        else if (pop)
            presented_next = 1'b0;
        else if (q_valid && !i_ready)
            presented_next = 1'b1;
    end

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting right
    assign lfsr_next = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_BYPASS: begin
                if (i_enable)
                    state_next = ST_DELAY;
            end
            ST_DELAY: begin
                if (!i_enable)
                    state_next = (count_next == '0) ? ST_BYPASS : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (i_enable)
                    state_next = ST_DELAY;
                else if (count_next == '0)
                    state_next = ST_BYPASS;
            end
            default: state_next = ST_BYPASS;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= ST_BYPASS;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            lfsr_reg      <= LFSR_SEED;
            presented_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            lfsr_reg      <= lfsr_next;
            presented_reg <= presented_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push)
            data_mem[wr_ptr_reg] <= i_d;
    end

    // Countdowns run per physical slot, so every held beat ages regardless of its queue position
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [DLY_W-1:0] cd_reg;

            always_ff @(posedge i_clk) begin
                if (i_rst)
                    cd_reg <= '0;
                else if (push && (wr_ptr_reg == PTR_W'(gi)))
                    cd_reg <= delay_load;
                else if (cd_reg != '0)
                    cd_reg <= cd_reg - DLY_W'(1);
            end

            assign cd_vec[gi] = cd_reg;
        end
    endgenerate

endmodule

// File: tb/tb_tvip_axi_sample_delay_fifo.sv
// Directed bench for tvip_axi_sample_delay_fifo: a per-cycle vector table for latency and
// ordering, plus hand-written sequences for backpressure, stalls, drain and reset.
module tb_tvip_axi_sample_delay_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  dly;
    logic [3:0]  thr;
    logic        vin;
    logic        o_ready;
    logic [31:0] din;
    logic        o_valid;
    logic        rdy;
    logic [31:0] dout;
    logic [3:0]  cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tvip_axi_sample_delay_fifo #(
        .DATA_WIDTH(32),
        .DEPTH(8),
        .MAX_DELAY(15),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_enable(en),
        .i_delay(dly),
        .i_stall_threshold(thr),
        .i_valid(vin),
        .o_ready(o_ready),
        .i_d(din),
        .o_valid(o_valid),
        .i_ready(rdy),
        .o_d(dout),
        .o_count(cnt)
    );

    typedef struct {
        logic        en;
        logic [3:0]  dly;
        logic [3:0]  thr;
        logic        vin;
        logic [31:0] din;
        logic        rdy;
        logic        exp_v;
        logic        exp_r;
        logic [31:0] exp_d;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic e, input logic [3:0] d, input logic [3:0] t,
                                input logic v, input logic [31:0] x, input logic r,
                                input logic ev, input logic er, input logic [31:0] ed,
                                input logic [3:0] ec);
        vec_t tmp;
        tmp.en = e; tmp.dly = d; tmp.thr = t; tmp.vin = v; tmp.din = x; tmp.rdy = r;
        tmp.exp_v = ev; tmp.exp_r = er; tmp.exp_d = ed; tmp.exp_cnt = ec;
        vecs.push_back(tmp);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [3:0] d, input logic [3:0] t,
                         input logic v, input logic [31:0] x, input logic r);
        en = e; dly = d; thr = t; vin = v; din = x; rdy = r;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int    exp_cnt2 [15];
        int    pop_idx;
        logic  sent9;
        logic  rose;

        exp_cnt2 = '{0, 1, 2, 3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0};

        // bypass pass-through right after reset, then enter DELAY
        add(0, 0, 0, 1, 32'hDEAD0001, 0, 1, 0, 32'hDEAD0001, 0);
        add(1, 0, 0, 0, 32'h0, 1, 0, 1, 32'h0, 0);
        // single beat at D=0: offered in the next cycle only
        add(1, 0, 0, 1, 32'h11, 1, 0, 1, 32'h0, 0);
        add(1, 0, 0, 0, 32'h0, 1, 1, 1, 32'h11, 1);
        add(1, 0, 0, 0, 32'h0, 1, 0, 1, 32'h0, 0);
        // eight back-to-back beats at D=5
        for (int j = 0; j < 15; j++)
            add(1, 5, 0, (j < 8), 32'(j), 1, (j >= 6 && j <= 13), 1, 32'(j - 6), 4'(exp_cnt2[j]));
        // A at D=4 followed by B at D=0: B must wait behind A
        add(1, 4, 0, 1, 32'hA0, 1, 0, 1, 32'h0, 0);
        add(1, 0, 0, 1, 32'hB0, 1, 0, 1, 32'h0, 1);
        add(1, 0, 0, 0, 32'h0, 1, 0, 1, 32'h0, 2);
        add(1, 0, 0, 0, 32'h0, 1, 0, 1, 32'h0, 2);
        add(1, 0, 0, 0, 32'h0, 1, 0, 1, 32'h0, 2);
        add(1, 0, 0, 0, 32'h0, 1, 1, 1, 32'hA0, 2);
        add(1, 0, 0, 0, 32'h0, 1, 1, 1, 32'hB0, 1);
        add(1, 0, 0, 0, 32'h0, 1, 0, 1, 32'h0, 0);

        // reset: outputs forced low even with upstream/downstream active
        rst = 1'b1;
        drive(0, 0, 0, 1, 32'hBEEF, 1);
        tick();
        tick();
        @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 0);
        chk("rst_count", cnt, 0);
        tick();
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].dly, vecs[i].thr, vecs[i].vin, vecs[i].din, vecs[i].rdy);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), o_valid, vecs[i].exp_v);
            chk($sformatf("vec%0d_ready", i), o_ready, vecs[i].exp_r);
            chk($sformatf("vec%0d_count", i), cnt, vecs[i].exp_cnt);
            if (vecs[i].exp_v)
                chk($sformatf("vec%0d_data", i), dout, vecs[i].exp_d);
            $display("vec %0d: vin=%0b din=%0h -> v=%0b r=%0b d=%0h cnt=%0d",
                     i, vecs[i].vin, vecs[i].din, o_valid, o_ready, dout, cnt);
            tick();
        end

        // fill to DEPTH with downstream blocked, then release
        for (int k = 0; k < 8; k++) begin
            drive(1, 0, 0, 1, 32'h300 + k, 0);
            @(negedge clk);
            chk($sformatf("fill%0d_ready", k), o_ready, 1);
            chk($sformatf("fill%0d_count", k), cnt, k);
            tick();
        end
        drive(1, 0, 0, 1, 32'h308, 0);
        @(negedge clk);
        chk("full_ready", o_ready, 0);
        chk("full_count", cnt, 8);
        chk("full_valid", o_valid, 1);
        chk("full_head", dout, 32'h300);
        tick();
        drive(1, 0, 0, 1, 32'h308, 1);
        pop_idx = 0;
        sent9   = 1'b0;
        for (int c = 0; c < 40 && pop_idx < 9; c++) begin
            @(negedge clk);
            if (c == 0)
                chk("full_no_comb_ready", o_ready, 0);
            if (o_valid) begin
                chk($sformatf("drain_pop%0d", pop_idx), dout, 32'h300 + pop_idx);
                $display("pop %0d: d=%0h cnt=%0d", pop_idx, dout, cnt);
                pop_idx++;
            end
            if (vin && o_ready)
                sent9 = 1'b1;
            tick();
            if (sent9)
                vin = 1'b0;
        end
        chk("fill_all_popped", pop_idx, 9);
        chk("fill_ninth_sent", sent9, 1);

        // heavy stall injection: once raised, valid/data hold while blocked
        drive(1, 0, 15, 1, 32'h55, 0);
        @(negedge clk);
        chk("stall_push_ready", o_ready, 1);
        tick();
        drive(1, 0, 15, 0, 32'h0, 0);
        rose = 1'b0;
        for (int w = 0; w < 2000 && !rose; w++) begin
            @(negedge clk);
            if (o_valid)
                rose = 1'b1;
            else
                tick();
        end
        chk("stall_valid_rose", rose, 1);
        if (rose) begin
            for (int k = 0; k < 10; k++) begin
                tick();
                @(negedge clk);
                chk($sformatf("stall_hold%0d_valid", k), o_valid, 1);
                chk($sformatf("stall_hold%0d_data", k), dout, 32'h55);
            end
            tick();
            drive(1, 0, 15, 0, 32'h0, 1);
            @(negedge clk);
            chk("stall_accept_valid", o_valid, 1);
            chk("stall_accept_data", dout, 32'h55);
        end
        tick();
        // threshold 0: back-to-back beats leave no gaps
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, 0, (k < 4), 32'h500 + k, 1);
            @(negedge clk);
            chk($sformatf("nostall%0d_valid", k), o_valid, (k >= 1 && k <= 4));
            if (k >= 1 && k <= 4)
                chk($sformatf("nostall%0d_data", k), dout, 32'h500 + k - 1);
            tick();
        end

        // drain: 3 held beats, enable dropped
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 1, 32'h61 + k, 0);
            @(negedge clk);
            chk($sformatf("drain_fill%0d_ready", k), o_ready, 1);
            tick();
        end
        drive(0, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
        chk("drain_enter_count", cnt, 3);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 32'h77, 1);
            @(negedge clk);
            chk($sformatf("drain%0d_ready", k), o_ready, 0);
            chk($sformatf("drain%0d_valid", k), o_valid, 1);
            chk($sformatf("drain%0d_data", k), dout, 32'h61 + k);
            tick();
        end
        @(negedge clk);
        chk("bypass_valid", o_valid, 1);
        chk("bypass_data", dout, 32'h77);
        chk("bypass_ready", o_ready, 1);
        chk("bypass_count", cnt, 0);
        tick();
        drive(0, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
        chk("bypass_idle_valid", o_valid, 0);
        chk("bypass_idle_ready", o_ready, 0);
        tick();

        // reset with 4 beats held discards them
        drive(1, 3, 0, 0, 32'h0, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1, 3, 0, 1, 32'h80 + k, 0);
            tick();
        end
        drive(1, 3, 0, 0, 32'h0, 0);
        @(negedge clk);
        chk("held_count", cnt, 4);
        tick();
        rst = 1'b1;
        drive(1, 0, 0, 1, 32'h99, 1);
        @(negedge clk);
        chk("rst_held_valid", o_valid, 0);
        chk("rst_held_ready", o_ready, 0);
        tick();
        rst = 1'b0;
        drive(1, 0, 0, 0, 32'h0, 1);
        @(negedge clk);
        chk("post_rst_count", cnt, 0);
        chk("post_rst_valid", o_valid, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            @(negedge clk);
            chk($sformatf("post_rst%0d_valid", k), o_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
